adder_tree_acc: RTL and testbench



---
 rtl/adder_tree_acc_pkg.sv | 26 ++
 rtl/adder_tree_acc_if.sv | 25 ++
 rtl/adder_tree_acc_stage.sv | 64 ++++++
 rtl/adder_tree_acc.sv | 133 +++++++++++++
 tb/tb_adder_tree_acc.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_tree_acc_pkg.sv
// Shared sizing helpers for the pipelined adder tree and its frame accumulator.
package adder_tree_pkg;

  function automatic int stages_of(input int n);
    return $clog2(n);
  endfunction

  function automatic int tree_lat_of(input int stages, input int reg_every);
    return (stages + reg_every - 1) / reg_every;
  endfunction

  // Operand width at the output of tree stage s (stage 0 is the raw input lanes).
  function automatic int stage_width(input int iw, input int s);
    return iw + s;
  endfunction

  // Lane count at the output of tree stage s; odd lanes are padded with zero.
  function automatic int stage_lanes(input int n, input int s);
    return (n + (1 << s) - 1) >> s;
  endfunction

  function automatic bit stage_is_reg(input int s, input int stages, input int reg_every);
    return ((s % reg_every) == 0) || (s == stages);
  endfunction

endpackage

// File: rtl/adder_tree_acc_if.sv
// Stream-in / result-out handshake bundle of the adder tree accumulator.
interface adder_tree_acc_if #(
  parameter int INPUTS_NUM  = 128,
  parameter int IDATA_WIDTH = 24,
  parameter int ACC_WIDTH   = IDATA_WIDTH + $clog2(INPUTS_NUM) + 16
);
  logic                   s_valid;
  logic                   s_ready;
  logic                   s_last;
  logic [IDATA_WIDTH-1:0] s_data [INPUTS_NUM];
  logic                   m_valid;
  logic                   m_ready;
  logic [ACC_WIDTH-1:0]   m_data;
  logic                   m_overflow;

  modport master (
    output s_valid, s_last, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_overflow
  );

  modport slave (
    input  s_valid, s_last, s_data, m_ready,
    output s_ready, m_valid, m_data, m_overflow
  );
endinterface

// File: rtl/adder_tree_acc_stage.sv
// One adder-tree level: pairwise widening add, optionally registered with valid/last tags.
module adder_tree_stage #(
  parameter int LANES_IN   = 2,
  parameter int IW         = 8,
  parameter bit SIGNED     = 1'b0,
  parameter bit REGISTERED = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 clear,
  input  logic                                 ce,
  input  logic                                 valid_i,
  input  logic                                 last_i,
  input  logic [LANES_IN-1:0][IW-1:0]          data_i,
  output logic                                 valid_o,
  output logic                                 last_o,
  output logic [(LANES_IN+1)/2-1:0][IW:0]      data_o
);
  localparam int LANES_OUT = (LANES_IN + 1) / 2;

  logic [LANES_OUT-1:0][IW:0] sum_d;

  for (genvar j = 0; j < LANES_OUT; j++) begin : g_pair
    logic [IW:0] a_ext;
    logic [IW:0] b_ext;
    assign a_ext = {(SIGNED ? data_i[2*j][IW-1] : 1'b0), data_i[2*j]};
    if (2*j + 1 < LANES_IN) begin : g_b
      assign b_ext = {(SIGNED ? data_i[2*j+1][IW-1] : 1'b0), data_i[2*j+1]};
    end else begin : g_pad
      assign b_ext = '0;
    end
    assign sum_d[j] = a_ext + b_ext;
  end

  if (REGISTERED) begin : g_reg
    logic [LANES_OUT-1:0][IW:0] sum_q;
    logic                       valid_q;
    logic                       last_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sum_q   <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (clear) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (ce) begin
        sum_q   <= sum_d;
        valid_q <= valid_i;
        last_q  <= last_i;
      end
    end

    assign data_o  = sum_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
  end else begin : g_comb
    assign data_o  = sum_d;
    assign valid_o = valid_i;
    assign last_o  = last_i;
  end

endmodule

// File: rtl/adder_tree_acc.sv
// Streaming adder tree reducing one wide beat per cycle, accumulating tree sums across
// an s_last-delimited frame and presenting one result per frame with backpressure.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int INPUTS_NUM  = 128,
  parameter int IDATA_WIDTH = 24,
  parameter bit SIGNED      = 1'b0,
  parameter int REG_EVERY   = 1,
  parameter int ACC_EXTRA   = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  adder_tree_acc_if.slave bus
);
  localparam int STAGES_NUM  = stages_of(INPUTS_NUM);
  localparam int ODATA_WIDTH = IDATA_WIDTH + STAGES_NUM;
  localparam int ACC_WIDTH   = ODATA_WIDTH + ACC_EXTRA;
  localparam int MSB         = ACC_WIDTH - 1;

  logic ce;
  logic m_valid_q, m_valid_d;

  // The whole pipeline advances in lockstep; only a held result can stall it.
  assign ce          = ~m_valid_q | bus.m_ready;
  assign bus.s_ready = ce;

  for (genvar s = 0; s <= STAGES_NUM; s++) begin : g_st
    localparam int LN = stage_lanes(INPUTS_NUM, s);
    localparam int W  = stage_width(IDATA_WIDTH, s);
    logic [LN-1:0][W-1:0] dat;
    logic                 vld;
    logic                 lst;

    if (s == 0) begin : g_in
      for (genvar i = 0; i < INPUTS_NUM; i++) begin : g_lane
        assign dat[i] = bus.s_data[i];
      end
      assign vld = bus.s_valid & ce;
      assign lst = bus.s_last;
    end else begin : g_lvl
      adder_tree_stage #(
        .LANES_IN  (stage_lanes(INPUTS_NUM, s - 1)),
        .IW        (W - 1),
        .SIGNED    (SIGNED),
        .REGISTERED(stage_is_reg(s, STAGES_NUM, REG_EVERY))
      ) u_stage (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear),
        .ce     (ce),
        .valid_i(g_st[s-1].vld),
        .last_i (g_st[s-1].lst),
        .data_i (g_st[s-1].dat),
        .valid_o(vld),
        .last_o (lst),
        .data_o (dat)
      );
    end
  end

  logic [ODATA_WIDTH-1:0] tree_sum;
  logic                   tree_valid;
  logic                   tree_last;
  assign tree_sum   = g_st[STAGES_NUM].dat[0];
  assign tree_valid = g_st[STAGES_NUM].vld;
  assign tree_last  = g_st[STAGES_NUM].lst;

  logic [ACC_WIDTH-1:0] sum_ext, acc_base, acc_next;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, m_data_q, m_data_d;
  logic                 carry, beat_ovf;
  logic                 first_q, first_d, frame_ovf_q, frame_ovf_d, m_ovf_q, m_ovf_d;

  assign sum_ext  = {{ACC_EXTRA{(SIGNED ? tree_sum[ODATA_WIDTH-1] : 1'b0)}}, tree_sum};
  assign acc_base = first_q ? '0 : acc_q;
  assign {carry, acc_next} = {1'b0, acc_base} + {1'b0, sum_ext};
  assign beat_ovf = SIGNED ? ((acc_base[MSB] == sum_ext[MSB]) && (acc_next[MSB] != acc_base[MSB]))
                           : carry;

  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    frame_ovf_d = frame_ovf_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_ovf_d     = m_ovf_q;
    if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;
    if (ce && tree_valid) begin
      if (tree_last) begin
        m_data_d    = acc_next;
        m_ovf_d     = frame_ovf_q | beat_ovf;
        m_valid_d   = 1'b1;
        first_d     = 1'b1;
        frame_ovf_d = 1'b0;
      end else begin
        acc_d       = acc_next;
        first_d     = 1'b0;
        frame_ovf_d = frame_ovf_q | beat_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      frame_ovf_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ovf_q     <= 1'b0;
    end else if (clear) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      frame_ovf_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ovf_q     <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      frame_ovf_q <= frame_ovf_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_ovf_q     <= m_ovf_d;
    end
  end

  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_overflow = m_ovf_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: 5 lanes x 8 bits, one unsigned and one signed instance.
module tb_adder_tree_acc;
  localparam int N  = 5;
  localparam int IW = 8;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  adder_tree_acc_if #(.INPUTS_NUM(N), .IDATA_WIDTH(IW), .ACC_WIDTH(AW)) ifu ();
  adder_tree_acc_if #(.INPUTS_NUM(N), .IDATA_WIDTH(IW), .ACC_WIDTH(AW)) ifs ();

  adder_tree_acc #(.INPUTS_NUM(N), .IDATA_WIDTH(IW), .SIGNED(1'b0), .REG_EVERY(1), .ACC_EXTRA(4))
    dut_u (.clk(clk), .reset_n(reset_n), .clear(clear), .bus(ifu.slave));
  adder_tree_acc #(.INPUTS_NUM(N), .IDATA_WIDTH(IW), .SIGNED(1'b1), .REG_EVERY(1), .ACC_EXTRA(4))
    dut_s (.clk(clk), .reset_n(reset_n), .clear(clear), .bus(ifs.slave));

  int total = 0;
  int bad = 0;
  logic [AW-1:0] rd_q[$];
  logic          ro_q[$];

  // Every completed handshake on the unsigned instance is logged in order.
  always @(posedge clk)
    if (reset_n && !clear && ifu.m_valid && ifu.m_ready) begin
      rd_q.push_back(ifu.m_data);
      ro_q.push_back(ifu.m_overflow);
    end

  task automatic send_u(input int base, input int step, input logic last);
    @(negedge clk);
    ifu.s_valid = 1'b1;
    ifu.s_last  = last;
    for (int i = 0; i < N; i++) ifu.s_data[i] = 8'(base + i * step);
    for (int k = 0; k < 50 && !ifu.s_ready; k++) @(negedge clk);
    @(posedge clk);
  endtask

  task automatic idle_u();
    @(negedge clk);
    ifu.s_valid = 1'b0;
    ifu.s_last  = 1'b0;
  endtask

  task automatic wait_res(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rd_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    total++; if (ifu.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", ifu.m_valid); end
    total++; if (ifu.m_data !== 15'd0) begin bad++; $display("FAIL reset_m_data got=%0d exp=0", ifu.m_data); end
    total++; if (ifu.m_overflow !== 1'b0) begin bad++; $display("FAIL reset_m_overflow got=%0b exp=0", ifu.m_overflow); end
    total++; if (ifu.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0b exp=1", ifu.s_ready); end
    total++; if (ifs.m_data !== 15'd0) begin bad++; $display("FAIL reset_signed_m_data got=%0d exp=0", ifs.m_data); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unsigned_latency();
    int lat;
    bit found;
    lat = 0;
    found = 1'b0;
    rd_q.delete(); ro_q.delete();
    @(negedge clk);
    ifu.s_valid = 1'b1;
    ifu.s_last  = 1'b1;
    for (int i = 0; i < N; i++) ifu.s_data[i] = 8'd255;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin ifu.s_valid = 1'b0; ifu.s_last = 1'b0; end
      if (ifu.m_valid) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL u_latency_timeout got=no_m_valid exp=m_valid"); end
    total++; if (lat != 4) begin bad++; $display("FAIL u_latency got=%0d exp=4", lat); end
    total++; if (ifu.m_data !== 15'd1275) begin bad++; $display("FAIL u_single_sum got=%0d exp=1275", ifu.m_data); end
    total++; if (ifu.m_overflow !== 1'b0) begin bad++; $display("FAIL u_single_ovf got=%0b exp=0", ifu.m_overflow); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_signed();
    int lat;
    bit found;
    lat = 0;
    found = 1'b0;
    @(negedge clk);
    ifs.s_valid = 1'b1;
    ifs.s_last  = 1'b1;
    for (int i = 0; i < N; i++) ifs.s_data[i] = 8'h80;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin ifs.s_valid = 1'b0; ifs.s_last = 1'b0; end
      if (ifs.m_valid) begin found = 1'b1; break; end
    end
    total++; if (!found || lat != 4) begin bad++; $display("FAIL s_latency got=%0d exp=4", lat); end
    total++; if (ifs.m_data !== 15'h7D80) begin bad++; $display("FAIL s_sum got=%h exp=7d80", ifs.m_data); end
    total++; if (ifs.m_overflow !== 1'b0) begin bad++; $display("FAIL s_ovf got=%0b exp=0", ifs.m_overflow); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    rd_q.delete(); ro_q.delete();
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 3; b++) send_u(1, 1, b == 2);
    idle_u();
    wait_res(2, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_timeout got=%0d exp=2 results", rd_q.size()); end
    total++; if (rd_q.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", rd_q.size()); end
    total++; if (rd_q[0] !== 15'd45) begin bad++; $display("FAIL b2b_frame0 got=%0d exp=45", rd_q[0]); end
    total++; if (rd_q[1] !== 15'd45) begin bad++; $display("FAIL b2b_frame1 got=%0d exp=45", rd_q[1]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    rd_q.delete(); ro_q.delete();
    @(negedge clk);
    ifu.m_ready = 1'b0;
    send_u(1, 1, 1'b1);
    send_u(2, 2, 1'b1);
    idle_u();
    for (int k = 0; k < 20 && !ifu.m_valid; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++; if (ifu.m_valid !== 1'b1) begin bad++; $display("FAIL bp_m_valid got=%0b exp=1", ifu.m_valid); end
    total++; if (ifu.s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready got=%0b exp=0", ifu.s_ready); end
    total++; if (ifu.m_data !== 15'd15) begin bad++; $display("FAIL bp_hold got=%0d exp=15", ifu.m_data); end
    @(negedge clk);
    total++; if (ifu.m_data !== 15'd15) begin bad++; $display("FAIL bp_hold2 got=%0d exp=15", ifu.m_data); end
    total++; if (rd_q.size() != 0) begin bad++; $display("FAIL bp_early got=%0d exp=0", rd_q.size()); end
    ifu.m_ready = 1'b1;
    wait_res(2, ok);
    total++; if (!ok || rd_q.size() != 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", rd_q.size()); end
    total++; if (rd_q[0] !== 15'd15) begin bad++; $display("FAIL bp_first got=%0d exp=15", rd_q[0]); end
    total++; if (rd_q[1] !== 15'd30) begin bad++; $display("FAIL bp_second got=%0d exp=30", rd_q[1]); end
  endtask

  task automatic test_overflow();
    bit ok;
    rd_q.delete(); ro_q.delete();
    for (int b = 0; b < 26; b++) send_u(255, 0, b == 25);
    send_u(1, 0, 1'b1);
    idle_u();
    wait_res(2, ok);
    total++; if (!ok || rd_q.size() != 2) begin bad++; $display("FAIL ovf_count got=%0d exp=2", rd_q.size()); end
    total++; if (rd_q[0] !== 15'd382) begin bad++; $display("FAIL ovf_wrap got=%0d exp=382", rd_q[0]); end
    total++; if (ro_q[0] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", ro_q[0]); end
    total++; if (rd_q[1] !== 15'd5) begin bad++; $display("FAIL ovf_next got=%0d exp=5", rd_q[1]); end
    total++; if (ro_q[1] !== 1'b0) begin bad++; $display("FAIL ovf_next_flag got=%0b exp=0", ro_q[1]); end
  endtask

  task automatic test_clear();
    bit ok;
    rd_q.delete(); ro_q.delete();
    send_u(7, 0, 1'b0);
    send_u(7, 0, 1'b0);
    @(negedge clk);
    ifu.s_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    send_u(2, 0, 1'b1);
    idle_u();
    wait_res(1, ok);
    total++; if (!ok || rd_q.size() != 1) begin bad++; $display("FAIL clr_count got=%0d exp=1", rd_q.size()); end
    total++; if (rd_q[0] !== 15'd10) begin bad++; $display("FAIL clr_sum got=%0d exp=10", rd_q[0]); end
    total++; if (ro_q[0] !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%0b exp=0", ro_q[0]); end
  endtask

  task automatic test_async_reset();
    bit ok;
    rd_q.delete(); ro_q.delete();
    send_u(7, 0, 1'b0);
    send_u(7, 0, 1'b0);
    idle_u();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (ifu.m_valid !== 1'b0) begin bad++; $display("FAIL arst_m_valid got=%0b exp=0", ifu.m_valid); end
    total++; if (ifu.m_data !== 15'd0) begin bad++; $display("FAIL arst_m_data got=%0d exp=0", ifu.m_data); end
    total++; if (ifu.m_overflow !== 1'b0) begin bad++; $display("FAIL arst_m_ovf got=%0b exp=0", ifu.m_overflow); end
    #10 reset_n = 1'b1;
    send_u(2, 0, 1'b1);
    idle_u();
    wait_res(1, ok);
    total++; if (!ok || rd_q.size() != 1) begin bad++; $display("FAIL arst_count got=%0d exp=1", rd_q.size()); end
    total++; if (rd_q[0] !== 15'd10) begin bad++; $display("FAIL arst_sum got=%0d exp=10", rd_q[0]); end
  endtask

  initial begin
    ifu.s_valid = 1'b0; ifu.s_last = 1'b0; ifu.m_ready = 1'b1;
    ifs.s_valid = 1'b0; ifs.s_last = 1'b0; ifs.m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      ifu.s_data[i] = '0;
      ifs.s_data[i] = '0;
    end
    test_reset();
    test_unsigned_latency();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
